// File: rtl/picorv32_mem_arb.sv
// Round-robin arbiter and access sequencer between the CPU port (0) and the NoC port (1)
// in front of a single-port memory with a registered one-cycle read latency.
module picorv32_mem_arb #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                p0_valid,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wstrb,
    output logic                p0_ready,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_valid,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wstrb,
    output logic                p1_ready,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                grant,
    output logic                busy,
    output logic [1:0]          dbg_state
);
    localparam int STRB_W = DATA_W / 8;

    // Handshake: a port holds valid with stable addr/wdata/wstrb until its
    // one-cycle ready pulse; rdata is valid only while ready is high.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_last_grant;
    logic                r_grant;
    logic [ADDR_W-1:0]   r_addr_q;
    logic [DATA_W-1:0]   r_wdata_q;
    logic [STRB_W-1:0]   r_wstrb_q;
    logic                w_load;
    logic                w_load_port;
    logic                w_p0_resp;
    logic                w_p1_resp;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // In RESP the granted port still holds valid, so only the other port can be taken.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_port  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (p0_valid || p1_valid) begin
                    w_load       = 1'b1;
                    w_load_port  = (p0_valid && p1_valid) ? ~r_last_grant : p1_valid;
                    w_next_state = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (r_grant ? p0_valid : p1_valid) begin
                    w_load       = 1'b1;
                    w_load_port  = ~r_grant;
                    w_next_state = S_ACCESS;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_wstrb_q    <= '0;
        end else if (w_load) begin
            r_last_grant <= w_load_port;
            r_grant      <= w_load_port;
            r_addr_q     <= w_load_port ? p1_addr  : p0_addr;
            r_wdata_q    <= w_load_port ? p1_wdata : p0_wdata;
            r_wstrb_q    <= w_load_port ? p1_wstrb : p0_wstrb;
        end
    end

    // Strobes reach the memory only in ACCESS, so each write hits it exactly once.
    always_comb begin
        w_p0_resp = (r_state == S_RESP) && !r_grant;
        w_p1_resp = (r_state == S_RESP) && r_grant;
        mem_addr  = r_addr_q;
        mem_wdata = r_wdata_q;
        mem_wstrb = (r_state == S_ACCESS) ? r_wstrb_q : '0;
        p0_ready  = w_p0_resp;
        p1_ready  = w_p1_resp;
        p0_rdata  = w_p0_resp ? mem_rdata : '0;
        p1_rdata  = w_p1_resp ? mem_rdata : '0;
        grant     = r_grant;
        busy      = (r_state != S_IDLE);
        dbg_state = r_state;
    end
endmodule

// File: tb/tb_picorv32_mem_arb.sv
// Directed bench for picorv32_mem_arb with a small registered-read RAM model
// mapped at 0x8000-0x80FF; anything else reads as zero and ignores writes.
module tb_picorv32_mem_arb;
    logic        clk;
    logic        resetn;
    logic        p0_valid;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic [3:0]  p0_wstrb;
    logic        p0_ready;
    logic [31:0] p0_rdata;
    logic        p1_valid;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic [3:0]  p1_wstrb;
    logic        p1_ready;
    logic [31:0] p1_rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        grant;
    logic        busy;
    logic [1:0]  dbg_state;

    int checks;
    int errors;
    int wstrb_pulses;

    logic [31:0] ram [0:63];

    picorv32_mem_arb #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_addr[31:8] == 24'h000080) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= ram[mem_addr[7:2]];
        end else begin
            mem_rdata <= '0;
        end
    end

    always @(negedge clk) begin
        if (mem_wstrb != 4'b0000) wstrb_pulses <= wstrb_pulses + 1;
    end

    task automatic apply_reset();
        resetn   = 1'b0;
        p0_valid = 1'b0; p0_addr = '0; p0_wdata = '0; p0_wstrb = '0;
        p1_valid = 1'b0; p1_addr = '0; p1_wdata = '0; p1_wstrb = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    // Full handshake on one port; returns read data. Bounded wait for ready.
    task automatic do_access(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, output logic [31:0] rdata);
        bit done;
        done  = 1'b0;
        rdata = '0;
        @(negedge clk);
        if (port == 0) begin
            p0_valid = 1'b1; p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb;
        end else begin
            p1_valid = 1'b1; p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb;
        end
        for (int i = 0; i < 8 && !done; i++) begin
            @(negedge clk);
            if (port == 0 && p0_ready) begin
                rdata = p0_rdata; p0_valid = 1'b0; done = 1'b1;
            end else if (port == 1 && p1_ready) begin
                rdata = p1_rdata; p1_valid = 1'b0; done = 1'b1;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL access_timeout port=%0d addr=%h got no ready, required ready", port, addr);
            p0_valid = 1'b0; p1_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant got=%b exp=0", grant); end
        checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL reset_wstrb got=%h exp=0", mem_wstrb); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_addr); end
        checks++; if ({p0_ready, p1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b exp=00", {p0_ready, p1_ready}); end
    endtask

    task automatic test_single_read();
        logic [31:0] rd;
        do_access(1, 32'h8004, 32'hDEADBEEF, 4'hF, rd);
        do_access(1, 32'h8008, 32'hAAAAAAAA, 4'hF, rd);
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 32'h8004; p0_wdata = 32'h0; p0_wstrb = 4'h0;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h8004) begin errors++; $display("FAIL read_c1_addr got=%h exp=00008004", mem_addr); end
        checks++; if (mem_wstrb !== 4'h0) begin errors++; $display("FAIL read_c1_wstrb got=%h exp=0", mem_wstrb); end
        checks++; if ({busy, p0_ready, p1_ready} !== 3'b100) begin errors++; $display("FAIL read_c1_status got=%b exp=100", {busy, p0_ready, p1_ready}); end
        @(negedge clk);
        checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL read_c2_ready got=%b exp=10", {p0_ready, p1_ready}); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_c2_rdata got=%h exp=deadbeef", p0_rdata); end
        p0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({busy, p0_ready, p1_ready} !== 3'b000) begin errors++; $display("FAIL read_c3_idle got=%b exp=000", {busy, p0_ready, p1_ready}); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd;
        int pulses0;
        pulses0 = wstrb_pulses;
        @(negedge clk);
        p1_valid = 1'b1; p1_addr = 32'h8008; p1_wdata = 32'h11223344; p1_wstrb = 4'b0010;
        @(negedge clk);
        checks++; if (mem_wstrb !== 4'b0010) begin errors++; $display("FAIL bw_c1_wstrb got=%b exp=0010", mem_wstrb); end
        checks++; if (p1_ready !== 1'b0) begin errors++; $display("FAIL bw_c1_ready got=%b exp=0", p1_ready); end
        @(negedge clk);
        checks++; if (mem_wstrb !== 4'b0000) begin errors++; $display("FAIL bw_c2_wstrb got=%b exp=0000", mem_wstrb); end
        checks++; if (p1_ready !== 1'b1) begin errors++; $display("FAIL bw_c2_ready got=%b exp=1", p1_ready); end
        p1_valid = 1'b0;
        do_access(0, 32'h8008, 32'h0, 4'h0, rd);
        checks++; if (rd !== 32'hAAAA33AA) begin errors++; $display("FAIL bw_readback got=%h exp=aaaa33aa", rd); end
        checks++; if (wstrb_pulses - pulses0 !== 1) begin errors++; $display("FAIL bw_pulses got=%0d exp=1", wstrb_pulses - pulses0); end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 32'h8004; p0_wstrb = 4'h0;
        p1_valid = 1'b1; p1_addr = 32'h8008; p1_wstrb = 4'h0;
        @(negedge clk);
        checks++; if ({dbg_state, grant} !== 3'b010) begin errors++; $display("FAIL sim_c1 state_grant got=%b exp=010", {dbg_state, grant}); end
        checks++; if (mem_addr !== 32'h8004) begin errors++; $display("FAIL sim_c1_addr got=%h exp=00008004", mem_addr); end
        @(negedge clk);
        checks++; if ({p0_ready, p1_ready} !== 2'b10) begin errors++; $display("FAIL sim_c2_ready got=%b exp=10", {p0_ready, p1_ready}); end
        checks++; if (p0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sim_c2_rdata got=%h exp=deadbeef", p0_rdata); end
        p0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({dbg_state, grant} !== 3'b011) begin errors++; $display("FAIL sim_c3 state_grant got=%b exp=011", {dbg_state, grant}); end
        checks++; if (mem_addr !== 32'h8008) begin errors++; $display("FAIL sim_c3_addr got=%h exp=00008008", mem_addr); end
        @(negedge clk);
        checks++; if ({p0_ready, p1_ready} !== 2'b01) begin errors++; $display("FAIL sim_c4_ready got=%b exp=01", {p0_ready, p1_ready}); end
        checks++; if (p1_rdata !== 32'hAAAA33AA) begin errors++; $display("FAIL sim_c4_rdata got=%h exp=aaaa33aa", p1_rdata); end
        p1_valid = 1'b0;
    endtask

    task automatic test_round_robin();
        int pulses0;
        int port;
        int idx;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [31:0] rd;
        pulses0 = wstrb_pulses;
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 32'h8020; p0_wdata = 32'h10000000; p0_wstrb = 4'hF;
        p1_valid = 1'b1; p1_addr = 32'h8040; p1_wdata = 32'h20000000; p1_wstrb = 4'hF;
        for (int k = 0; k < 8; k++) begin
            port     = k % 2;
            idx      = k / 2;
            exp_addr = (port == 1 ? 32'h8040 : 32'h8020) + 32'(4 * idx);
            exp_data = (port == 1 ? 32'h20000000 : 32'h10000000) + 32'(idx);
            @(negedge clk);
            checks++; if (grant !== port[0]) begin errors++; $display("FAIL rr_grant k=%0d got=%b exp=%b", k, grant, port[0]); end
            checks++; if ({mem_addr, mem_wdata, mem_wstrb} !== {exp_addr, exp_data, 4'hF}) begin
                errors++; $display("FAIL rr_access k=%0d got=%h/%h/%h exp=%h/%h/f", k, mem_addr, mem_wdata, mem_wstrb, exp_addr, exp_data);
            end
            @(negedge clk);
            checks++; if ({p1_ready, p0_ready} !== (port == 1 ? 2'b10 : 2'b01)) begin
                errors++; $display("FAIL rr_ready k=%0d got=%b%b port=%0d", k, p1_ready, p0_ready, port);
            end
            if (port == 0) begin
                if (idx < 3) begin p0_addr = p0_addr + 4; p0_wdata = p0_wdata + 1; end
                else p0_valid = 1'b0;
            end else begin
                if (idx < 3) begin p1_addr = p1_addr + 4; p1_wdata = p1_wdata + 1; end
                else p1_valid = 1'b0;
            end
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_busy got=%b exp=0", busy); end
        checks++; if (wstrb_pulses - pulses0 !== 8) begin errors++; $display("FAIL rr_pulses got=%0d exp=8", wstrb_pulses - pulses0); end
        do_access(0, 32'h8044, 32'h0, 4'h0, rd);
        checks++; if (rd !== 32'h20000001) begin errors++; $display("FAIL rr_readback got=%h exp=20000001", rd); end
    endtask

    task automatic test_reset_mid_write();
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 32'h8010; p0_wdata = 32'h55555555; p0_wstrb = 4'hF;
        @(negedge clk);
        checks++; if (mem_wstrb !== 4'hF) begin errors++; $display("FAIL rmw_access_wstrb got=%h exp=f", mem_wstrb); end
        resetn = 1'b0; p0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({mem_wstrb, busy, p0_ready, grant} !== 7'b0) begin
            errors++; $display("FAIL rmw_after_reset wstrb/busy/ready/grant got=%h/%b/%b/%b exp=0/0/0/0", mem_wstrb, busy, p0_ready, grant);
        end
        resetn = 1'b1;
        p0_valid = 1'b1; p0_addr = 32'h8004; p0_wdata = 32'h0; p0_wstrb = 4'h0;
        @(negedge clk);
        checks++; if ({busy, p0_ready, mem_addr} !== {2'b10, 32'h8004}) begin
            errors++; $display("FAIL rmw_c1 busy/ready/addr got=%b/%b/%h exp=1/0/00008004", busy, p0_ready, mem_addr);
        end
        @(negedge clk);
        checks++; if ({p0_ready, p0_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            errors++; $display("FAIL rmw_c2 ready/rdata got=%b/%h exp=1/deadbeef", p0_ready, p0_rdata);
        end
        p0_valid = 1'b0;
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        p0_valid = 1'b1; p0_addr = 32'h00010000; p0_wdata = 32'h0; p0_wstrb = 4'h0;
        @(negedge clk);
        checks++; if (mem_addr !== 32'h00010000) begin errors++; $display("FAIL oor_addr got=%h exp=00010000", mem_addr); end
        @(negedge clk);
        checks++; if ({p0_ready, p0_rdata} !== {1'b1, 32'h0}) begin
            errors++; $display("FAIL oor_resp ready/rdata got=%b/%h exp=1/00000000", p0_ready, p0_rdata);
        end
        p0_valid = 1'b0;
        @(negedge clk);
        checks++; if ({dbg_state, busy} !== 3'b000) begin errors++; $display("FAIL oor_idle state/busy got=%b exp=000", {dbg_state, busy}); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        wstrb_pulses = 0;
        test_reset();
        test_single_read();
        test_byte_write();
        test_simultaneous();
        test_round_robin();
        test_reset_mid_write();
        test_out_of_range();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/picorv32_mem_arb.md
# picorv32_mem_arb

Two-requester arbiter and access sequencer for the single-port PicoRV32 BRAM/BROM memory block. It sits between the CPU native memory port (port 0) and the NoC DMA/loader port (port 1), and runs the memory's registered one-cycle read latency. It also guarantees that `mem_wstrb` is non-zero only during the one cycle of a granted write. Arbitration is round-robin with a fixed per-access sequence.

## Interface
- `ADDR_W`, default 32: address width on both requester ports and the memory side.
- `DATA_W`, default 32: data width; `DATA_W/8` strobe bits.
- `clk` in 1: single clock for the arbiter and the memory block.
- `resetn` in 1: synchronous, active-low reset.
- `p0_valid` in 1: port 0 (CPU) request. Held high with stable addr/wdata/wstrb until `p0_ready`.
- `p0_addr` in `ADDR_W`: port 0 byte address.
- `p0_wdata` in `DATA_W`: port 0 write data.
- `p0_wstrb` in `DATA_W/8`: port 0 byte enables; 0 means read.
- `p0_ready` out 1: one-cycle completion pulse for port 0.
- `p0_rdata` out `DATA_W`: port 0 read data; valid only while `p0_ready`=1.
- `p1_valid`, `p1_addr`, `p1_wdata`, `p1_wstrb`, `p1_ready`, `p1_rdata`: same directions, widths and meanings for port 1 (NoC).
- `mem_addr` out `ADDR_W`: byte address to the memory block.
- `mem_wdata` out `DATA_W`: write data to the memory block.
- `mem_wstrb` out `DATA_W/8`: byte write enables to the memory block.
- `mem_rdata` in `DATA_W`: memory read data; valid one cycle after the address is presented.
- `grant` out 1: port currently owning the memory (0 or 1). Meaningful only while `busy`=1.
- `busy` out 1: high in ACCESS and RESP.

## Operation
- The FSM has three states: IDLE, ACCESS, RESP.
- **IDLE**
  - If no port is valid, remain in IDLE.
  - If any port is valid, select a winner, latch its addr/wdata/wstrb into `addr_q`/`wdata_q`/`wstrb_q`, set `grant`, and go to ACCESS.
- **Winner selection**
  - If only one port is valid, it wins.
  - If both are valid, the port that is not `last_grant` wins.
  - `last_grant` updates on every grant. It resets to 1, so port 0 wins the first tie.
- **ACCESS**
  - `mem_addr`=`addr_q`, `mem_wdata`=`wdata_q`, `mem_wstrb`=`wstrb_q`.
  - The memory samples at the end of this cycle.
  - Always go to RESP.
- **RESP**
  - `p<grant>_ready`=1 and `p<grant>_rdata`=`mem_rdata`, passed through combinationally. Writes also complete here; rdata is don't-care for writes.
  - The granted port's `valid` is ignored in this cycle, because it is still high.
  - If the other port's `valid`=1, latch that port's request, grant it, and go directly to ACCESS.
  - Otherwise go to IDLE.
- **Outputs outside these cases**
  - `mem_wstrb`=0 in IDLE and RESP. This is mandatory, since any non-zero strobe writes the memory.
  - `mem_addr`/`mem_wdata` hold `addr_q`/`wdata_q`. No spurious write is possible because `mem_wstrb`=0.
  - `pN_ready`=0 and `pN_rdata`=0 except as defined for RESP.
- **Address handling**
  - Addresses pass through unmodified. Region decode, word alignment and out-of-range behaviour belong to the memory block.
  - Out-of-range reads return whatever `mem_rdata` presents (0).
- **Reset**, at any state (including mid-ACCESS or RESP), on the next edge:
  - state=IDLE, `last_grant`=1, `addr_q`/`wdata_q`/`wstrb_q`=0.
  - `mem_wstrb`=0, both `ready`=0, `busy`=0, `grant`=0.
  - An interrupted request is dropped and never acknowledged.

## Timing
- Request latency: `valid` first high in IDLE at cycle t → ACCESS at t+1 → `ready` at t+2.
- Throughput:
  - Alternating ports: one access per 2 cycles (RESP→ACCESS).
  - A single port: one access per 3 cycles, because the requester drops `valid` after `ready` and the FSM returns to IDLE.
- The losing port waits at most one full access, so a continuously valid port never starves.
- `mem_wstrb` is non-zero for exactly one cycle per write and zero for every read.

## Test plan
- **Single read.** Preload word 0x0000_8004 = 0xDEADBEEF. Assert `p0_valid` with addr 0x8004 and wstrb 0 at cycle 0.
  - Cycle 1: `mem_addr`=0x8004, `mem_wstrb`=0.
  - Cycle 2: `p0_ready`=1, `p0_rdata`=0xDEADBEEF.
  - `p1_ready` stays 0 throughout.
- **Byte write.** Port 1 writes addr 0x8008, wdata 0x11223344, wstrb 4'b0010, over a word holding 0xAAAAAAAA.
  - `mem_wstrb`=0010 for exactly one cycle, followed by `p1_ready`.
  - A subsequent read returns 0xAAAA33AA.
- **Simultaneous first requests after reset.** Both ports assert `valid` at cycle 0.
  - Port 0 gets `p0_ready` at cycle 2 (tie goes to port 0 after reset).
  - The FSM goes RESP→ACCESS, and port 1 gets `p1_ready` at cycle 4.
- **Round-robin.** Both ports re-request immediately after each `ready` for 8 accesses.
  - Grants alternate 0,1,0,1,…
  - Neither port waits more than one access.
  - Exactly 8 one-cycle `mem_wstrb` write pulses occur for 8 writes.
- **Reset mid-write.** Drop `resetn` during the ACCESS cycle of a port-0 write to 0x8010.
  - On the next edge: `mem_wstrb`=0, `busy`=0, no `p0_ready`.
  - After release, a new port-0 request completes with normal 2-cycle latency.
- **Out-of-range read.** Port 0 reads 0x0001_0000 (outside ROM and RAM).
  - `p0_ready` at cycle 2 with `p0_rdata`=0.
  - The FSM returns to IDLE.
